id_stage: RTL

- Instruction-decode stage of the RV32I core; the producing end of the ALU operand interface.
- Accepts fetched instructions over a valid/ready handshake and decodes opcode/funct fields.
- Reads the 32x32 register file, generates immediates and selects operands.
- Presents a registered, stall-able decoded bundle (opcode_reg, funct3_reg, funct7_reg, SrcA, SrcB, plus side data) to the execute stage.

---
 rtl/id_stage.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/id_stage.sv
// rtl/id_stage.sv - RV32I decode stage: register file, immediates, operand select, stall-able output bundle
module id_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_valid,
    output logic        if_ready,
    input  logic [31:0] if_instr,
    input  logic [31:0] if_pc,
    output logic        ex_valid,
    input  logic        ex_ready,
    input  logic        flush,
    input  logic        wb_we,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    output logic [6:0]  opcode_reg,
    output logic [2:0]  funct3_reg,
    output logic [6:0]  funct7_reg,
    output logic [31:0] SrcA,
    output logic [31:0] SrcB,
    output logic [31:0] rs2_data,
    output logic [4:0]  rd_reg,
    output logic [31:0] pc_reg,
    output logic        illegal
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    logic [31:0] rf [0:31];

    logic [4:0]  rs1, rs2;
    logic [31:0] rs1_val, rs2_val;
    logic [31:0] imm_i, imm_s, imm_u, imm_j;
    logic        is_shift;
    logic [31:0] dec_a, dec_b;
    logic [6:0]  dec_f7;
    logic [4:0]  dec_rd;
    logic        dec_ill;
    logic        load;

    assign if_ready = !ex_valid || ex_ready;
    assign load     = if_valid && if_ready;

    assign rs1 = if_instr[19:15];
    assign rs2 = if_instr[24:20];

    // Write-back bypass so an instruction decoded in the same cycle as its producer's write sees the new value
    always_comb begin
        rs1_val = rf[rs1];
        if (rs1 == 5'd0)
            rs1_val = 32'd0;
        else if (wb_we && wb_rd == rs1)
            rs1_val = wb_data;
        rs2_val = rf[rs2];
        if (rs2 == 5'd0)
            rs2_val = 32'd0;
        else if (wb_we && wb_rd == rs2)
            rs2_val = wb_data;
    end

    assign imm_i = {{20{if_instr[31]}}, if_instr[31:20]};
    assign imm_s = {{20{if_instr[31]}}, if_instr[31:25], if_instr[11:7]};
    assign imm_u = {if_instr[31:12], 12'b0};
    assign imm_j = {{11{if_instr[31]}}, if_instr[31], if_instr[19:12], if_instr[20], if_instr[30:21], 1'b0};
    assign is_shift = (if_instr[14:12] == 3'b001) || (if_instr[14:12] == 3'b101);

    always_comb begin
        dec_a   = 32'd0;
        dec_b   = 32'd0;
        dec_f7  = 7'd0;
        dec_rd  = if_instr[11:7];
        dec_ill = 1'b0;
        case (if_instr[6:0])
            OP_R: begin
                dec_a  = rs1_val;
                dec_b  = is_shift ? {27'd0, rs2_val[4:0]} : rs2_val;
                dec_f7 = if_instr[31:25];
            end
            OP_IMM: begin
                dec_a  = rs1_val;
                dec_b  = is_shift ? {27'd0, if_instr[24:20]} : imm_i;
                // Non-shift OP-IMM must not leak immediate bits into funct7 (addi -1 would look like sub)
                dec_f7 = is_shift ? if_instr[31:25] : 7'd0;
            end
            OP_LOAD, OP_JALR: begin
                dec_a = rs1_val;
                dec_b = imm_i;
            end
            OP_STORE: begin
                dec_a  = rs1_val;
                dec_b  = imm_s;
                dec_rd = 5'd0;
            end
            OP_BRANCH: begin
                dec_a  = rs1_val;
                dec_b  = rs2_val;
                dec_rd = 5'd0;
            end
            OP_JAL: begin
                dec_a = if_pc;
                dec_b = imm_j;
            end
            OP_LUI: begin
                dec_b = imm_u;
            end
            OP_AUIPC: begin
                dec_a = if_pc;
                dec_b = imm_u;
            end
            default: begin
                dec_rd  = 5'd0;
                dec_ill = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++)
                rf[i] <= 32'd0;
        end else if (wb_we && wb_rd != 5'd0) begin
            rf[wb_rd] <= wb_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid   <= 1'b0;
            illegal    <= 1'b0;
            opcode_reg <= 7'd0;
            funct3_reg <= 3'd0;
            funct7_reg <= 7'd0;
            SrcA       <= 32'd0;
            SrcB       <= 32'd0;
            rs2_data   <= 32'd0;
            rd_reg     <= 5'd0;
            pc_reg     <= RESET_PC;
        end else if (flush) begin
            ex_valid <= 1'b0;
        end else if (load) begin
            ex_valid   <= 1'b1;
            illegal    <= dec_ill;
            opcode_reg <= if_instr[6:0];
            funct3_reg <= if_instr[14:12];
            funct7_reg <= dec_f7;
            SrcA       <= dec_a;
            SrcB       <= dec_b;
            rs2_data   <= rs2_val;
            rd_reg     <= dec_rd;
            pc_reg     <= if_pc;
        end else if (ex_ready) begin
            ex_valid <= 1'b0;
        end
    end

endmodule
